// File: rtl/lif_membrane_integrator.sv
// Leaky integrate-and-fire membrane: saturating weight accumulation, per-step leak, threshold compare, refractory hold.
// Latency: step at t -> leaked potential visible t+2, spike pulse during t+3; weight accepted in IDLE lands next cycle.
// Backpressure: weight_ready_o low outside IDLE (LEAK/CMP) and during reset; steps arriving while busy are dropped.
module lif_membrane_integrator #(
    parameter int DSIZE     = 16,
    parameter int REFRACT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 weight_valid_i,
    input  logic [DSIZE-1:0]     weight_i,
    output logic                 weight_ready_o,
    input  logic                 step_i,
    input  logic [DSIZE-1:0]     leak_i,
    input  logic [DSIZE-1:0]     threshold_i,
    input  logic [DSIZE-1:0]     reset_potential_i,
    input  logic [REFRACT_W-1:0] refractory_i,
    output logic                 spike_o,
    output logic [DSIZE-1:0]     potential_o,
    output logic                 refractory_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAK = 2'd1,
        CMP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DSIZE-1:0]     pot_q, pot_d;
    logic [REFRACT_W-1:0] refr_q, refr_d;
    logic                 spike_q, spike_d;

    logic [DSIZE:0]       add_ext;
    logic [DSIZE:0]       sub_ext;
    logic                 fire;

    // Clamp a DSIZE+1 bit result: the extra sign bit disagreeing with the MSB means overflow,
    // and the extra bit tells which rail to clamp to.
    function automatic logic [DSIZE-1:0] sat(input logic [DSIZE:0] ext);
        if (ext[DSIZE] != ext[DSIZE-1])
            return ext[DSIZE] ? {1'b1, {(DSIZE-1){1'b0}}} : {1'b0, {(DSIZE-1){1'b1}}};
        else
            return ext[DSIZE-1:0];
    endfunction

    assign add_ext = {pot_q[DSIZE-1], pot_q} + {weight_i[DSIZE-1], weight_i};
    assign sub_ext = {pot_q[DSIZE-1], pot_q} - {leak_i[DSIZE-1], leak_i};
    assign fire    = $signed(pot_q) >= $signed(threshold_i);

    assign weight_ready_o = (state_q == IDLE) && !rst;
    assign refractory_o   = (refr_q != '0);
    assign spike_o        = spike_q;
    assign potential_o    = pot_q;

    // Next-state: integrate in IDLE, leak in LEAK, fire decision in CMP.
    always_comb begin
        state_d = state_q;
        pot_d   = pot_q;
        refr_d  = refr_q;
        spike_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Weights seen while refractory are consumed but discarded.
                if (weight_valid_i && (refr_q == '0))
                    pot_d = sat(add_ext);
                if (step_i) begin
                    if (refr_q == '0)
                        state_d = LEAK;
                    else
                        refr_d = refr_q - REFRACT_W'(1);
                end
            end
            LEAK: begin
                pot_d   = sat(sub_ext);
                state_d = CMP;
            end
            CMP: begin
                if (fire) begin
                    spike_d = 1'b1;
                    pot_d   = reset_potential_i;
                    refr_d  = refractory_i;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; reset also kills a spike about to be issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pot_q   <= '0;
            refr_q  <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pot_q   <= pot_d;
            refr_q  <= refr_d;
            spike_q <= spike_d;
        end
    end

endmodule

// File: tb/tb_lif_membrane_integrator.sv
// Testbench for lif_membrane_integrator: directed scenarios plus randomized traffic against an integer reference model.
// Model tracks potential as a plain int with explicit clamping and a countdown of pending step work.
// Inputs driven on the falling edge; outputs sampled on the falling edge after each rising edge.
module tb_lif_membrane_integrator;

    localparam int DSIZE     = 16;
    localparam int REFRACT_W = 4;
    localparam int PMAX      = 32767;
    localparam int PMIN      = -32768;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 weight_valid_i;
    logic [DSIZE-1:0]     weight_i;
    logic                 weight_ready_o;
    logic                 step_i;
    logic [DSIZE-1:0]     leak_i;
    logic [DSIZE-1:0]     threshold_i;
    logic [DSIZE-1:0]     reset_potential_i;
    logic [REFRACT_W-1:0] refractory_i;
    logic                 spike_o;
    logic [DSIZE-1:0]     potential_o;
    logic                 refractory_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_pot   = 0;
    int m_refr  = 0;
    int m_busy  = 0;   // remaining cycles of step processing: 2 = leak next, 1 = compare next
    int m_spike = 0;

    always #5 clk = ~clk;

    lif_membrane_integrator #(.DSIZE(DSIZE), .REFRACT_W(REFRACT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .weight_valid_i    (weight_valid_i),
        .weight_i          (weight_i),
        .weight_ready_o    (weight_ready_o),
        .step_i            (step_i),
        .leak_i            (leak_i),
        .threshold_i       (threshold_i),
        .reset_potential_i (reset_potential_i),
        .refractory_i      (refractory_i),
        .spike_o           (spike_o),
        .potential_o       (potential_o),
        .refractory_o      (refractory_o)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > PMAX) return PMAX;
        if (v < PMIN) return PMIN;
        return v;
    endfunction

    // One clock: drive inputs, check ready, advance model and DUT, compare outputs.
    task automatic cyc(input bit v, input int w, input bit s, input bit r);
        int  nw, nl, nt;
        bit  exp_rdy;
        weight_valid_i = v;
        weight_i       = w[DSIZE-1:0];
        step_i         = s;
        rst            = r;
        #1;
        exp_rdy = !r && (m_busy == 0);
        chk("weight_ready", int'(weight_ready_o), int'(exp_rdy));
        nw = int'($signed(weight_i));
        nl = int'($signed(leak_i));
        nt = int'($signed(threshold_i));
        m_spike = 0;
        if (r) begin
            m_pot = 0; m_refr = 0; m_busy = 0;
        end else if (m_busy == 0) begin
            if (v && m_refr == 0) m_pot = clamp(m_pot + nw);
            if (s) begin
                if (m_refr == 0) m_busy = 2;
                else m_refr = m_refr - 1;
            end
        end else if (m_busy == 2) begin
            m_pot  = clamp(m_pot - nl);
            m_busy = 1;
        end else begin
            if (m_pot >= nt) begin
                m_spike = 1;
                m_pot   = int'($signed(reset_potential_i));
                m_refr  = int'(refractory_i);
            end
            m_busy = 0;
        end
        @(negedge clk);
        chk("spike", int'(spike_o), m_spike);
        chk("potential", int'($signed(potential_o)), m_pot);
        chk("refractory", int'(refractory_o), int'(m_refr != 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input int lk, input int th, input int rp, input int rf);
        leak_i            = lk[DSIZE-1:0];
        threshold_i       = th[DSIZE-1:0];
        reset_potential_i = rp[DSIZE-1:0];
        refractory_i      = rf[REFRACT_W-1:0];
    endtask

    int prev_spike;

    initial begin
        weight_valid_i = 1'b0; weight_i = '0; step_i = 1'b0; rst = 1'b1;
        cfg(1, 100, 0, 0);
        @(negedge clk);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("reset_pot", int'(potential_o), 0);
        chk("reset_spike", int'(spike_o), 0);

        // Accumulate then step: 110 -> 109 -> spike, reset to 0
        cyc(1'b1, 40, 1'b0, 1'b0);
        cyc(1'b1, 40, 1'b0, 1'b0);
        cyc(1'b1, 30, 1'b0, 1'b0);
        chk("acc_110", int'($signed(potential_o)), 110);
        cyc(1'b0, 0, 1'b1, 1'b0);   // t
        cyc(1'b0, 0, 1'b0, 1'b0);   // t+1 -> potential t+2
        chk("leak_109", int'($signed(potential_o)), 109);
        chk("no_early_spike", int'(spike_o), 0);
        cyc(1'b0, 0, 1'b0, 1'b0);   // t+3
        chk("spike_t3", int'(spike_o), 1);
        chk("reset_loaded", int'($signed(potential_o)), 0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        chk("spike_one_cycle", int'(spike_o), 0);

        // Equal-to-threshold fires (101-1=100), 100-1=99 does not
        cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b1, 101, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0);
        idle(2);
        chk("eq_thr_fires", int'(spike_o), 1);
        cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b1, 100, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0);
        idle(2);
        chk("below_thr_quiet", int'(spike_o), 0);
        chk("below_thr_pot", int'($signed(potential_o)), 99);

        // Saturation
        cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b1, 'h7F00, 1'b0, 1'b0);
        cyc(1'b1, 'h0200, 1'b0, 1'b0);
        chk("sat_pos", int'(potential_o), 'h7FFF);
        cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b1, 'h8100, 1'b0, 1'b0);
        cyc(1'b1, 'hFE00, 1'b0, 1'b0);
        chk("sat_neg", int'(potential_o), 'h8000);
        cyc(1'b0, 0, 1'b0, 1'b1);
        cfg(-5, 100, 0, 0);
        cyc(1'b1, 'h7FFF, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        chk("sat_leak", int'(potential_o), 'h7FFF);
        idle(2);

        // Refractory for 2 steps
        cyc(1'b0, 0, 1'b0, 1'b1);
        cfg(0, 100, 0, 2);
        cyc(1'b1, 150, 1'b1, 1'b0);
        idle(2);
        chk("refr_spike", int'(spike_o), 1);
        chk("refr_high", int'(refractory_o), 1);
        cyc(1'b1, 200, 1'b0, 1'b0);
        chk("refr_discard", int'($signed(potential_o)), 0);
        cyc(1'b0, 0, 1'b1, 1'b0);
        chk("refr_still", int'(refractory_o), 1);
        cyc(1'b0, 0, 1'b1, 1'b0);
        chk("refr_fell", int'(refractory_o), 0);
        cyc(1'b1, 120, 1'b1, 1'b0);
        idle(2);
        chk("refr_third_step", int'(spike_o), 1);
        idle(1);

        // Handshake: held valid across LEAK/CMP, step in LEAK dropped
        cyc(1'b0, 0, 1'b0, 1'b1);
        cfg(1, 1000, 0, 0);
        cyc(1'b1, 10, 1'b1, 1'b0);   // weight before leak
        chk("busy_ready", int'(weight_ready_o), 0);
        cyc(1'b1, 5, 1'b1, 1'b0);    // LEAK: dropped step, held weight
        chk("leak_incl_weight", int'($signed(potential_o)), 9);
        cyc(1'b1, 5, 1'b0, 1'b0);    // CMP
        cyc(1'b1, 5, 1'b0, 1'b0);    // IDLE accept
        chk("held_accepted", int'($signed(potential_o)), 14);
        idle(3);
        chk("dropped_step", int'($signed(potential_o)), 14);

        // Reset during CMP with potential above threshold
        cfg(1, 100, 0, 3);
        cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b1, 150, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1);    // rst in CMP
        chk("rst_no_spike", int'(spike_o), 0);
        chk("rst_pot", int'(potential_o), 0);
        chk("rst_refr", int'(refractory_o), 0);
        idle(2);

        // Randomized traffic
        prev_spike = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0)
                cfg($urandom_range(0, 40) - 10, $urandom_range(0, 3000) - 500,
                    $urandom_range(0, 200) - 100, $urandom_range(0, 3));
            cyc(($urandom_range(0, 3) != 0),
                (($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                               : int'($urandom_range(0, 600)) - 200),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 199) == 0));
            if (prev_spike == 1 && spike_o == 1'b1) chk("spike_back_to_back", 1, 0);
            prev_spike = int'(spike_o);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
